register_file_mp: RTL and testbench

Multi-ported, parametrised register file. It is the next generation of the core's integer register file, for the dual-issue pipeline. It adds configurable read and write port counts, same-address write arbitration, and a per-register pending-write scoreboard. Issue reserves a destination register and writeback clears the reservation. The block sits between decode/issue, which reads operands and reserves destinations, and the writeback stage.

---
 rtl/register_file_mp_if.sv | 30 +++
 rtl/register_file_mp.sv | 109 ++++++++++
 tb/tb_register_file_mp.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: operand reads, writeback writes, destination reservation.
// master = issue/writeback side, slave = the register file.
interface register_file_mp_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned REG_DEPTH  = 32,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned NUM_WR     = 2
);
    logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] o_rd_data;
    logic [NUM_RD-1:0]            o_rd_busy;
    logic [NUM_WR-1:0]            i_wr_en;
    logic [NUM_WR*ADDR_WIDTH-1:0] i_wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0] i_wr_data;
    logic                         i_res_en;
    logic [ADDR_WIDTH-1:0]        i_res_addr;
    logic                         o_res_ready;
    logic [REG_DEPTH-1:0]         o_busy_vec;

    modport master (
        output i_rd_addr, i_wr_en, i_wr_addr, i_wr_data, i_res_en, i_res_addr,
        input  o_rd_data, o_rd_busy, o_res_ready, o_busy_vec
    );

    modport slave (
        input  i_rd_addr, i_wr_en, i_wr_addr, i_wr_data, i_res_en, i_res_addr,
        output o_rd_data, o_rd_busy, o_res_ready, o_busy_vec
    );
endinterface

// File: rtl/register_file_mp.sv
// Multi-ported integer register file with per-register pending-write scoreboard.
// Optional write-through forwarding on reads: define REGFILE_BYPASS_EN.
module register_file_mp #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned REG_DEPTH  = 32,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned NUM_WR     = 2
) (
    input logic               i_clk,
    input logic               i_arst,
    register_file_mp_if.slave bus
);

    logic [DATA_WIDTH-1:0]        regs   [REG_DEPTH];
    logic [REG_DEPTH-1:0]         busy;
    logic [REG_DEPTH-1:0]         wr_hit;
    logic [DATA_WIDTH-1:0]        wr_val [REG_DEPTH];
    logic [REG_DEPTH-1:0]         res_set;
    logic                         res_busy;
    logic                         res_wr;
    logic                         res_ready_c;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_c;
    logic [NUM_RD-1:0]            rd_busy_c;

    // Per-register write decode; ascending port scan lets the highest port win.
    // Register 0 is never decoded, so it is never written nor cleared.
    always_comb begin : wr_decode
        wr_hit = '0;
        for (int unsigned r = 0; r < REG_DEPTH; r++) begin
            wr_val[r] = '0;
        end
        for (int unsigned r = 1; r < REG_DEPTH; r++) begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (bus.i_wr_en[j] &&
                    bus.i_wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = bus.i_wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // A pending register can be re-reserved only when its producer writes back this cycle.
    always_comb begin : res_decode
        res_busy = 1'b0;
        res_wr   = 1'b0;
        res_set  = '0;
        for (int unsigned r = 0; r < REG_DEPTH; r++) begin
            if (bus.i_res_addr == ADDR_WIDTH'(r)) begin
                res_busy = busy[r];
                res_wr   = wr_hit[r];
            end
        end
        res_ready_c = !res_busy || res_wr || (bus.i_res_addr == '0);
        for (int unsigned r = 1; r < REG_DEPTH; r++) begin
            if (bus.i_res_en && res_ready_c && bus.i_res_addr == ADDR_WIDTH'(r)) begin
                res_set[r] = 1'b1;
            end
        end
    end

    // Storage and scoreboard; a new reservation supersedes a same-cycle writeback.
    always_ff @(posedge i_clk or posedge i_arst) begin : state_q
        if (i_arst) begin
            busy <= '0;
            for (int unsigned r = 0; r < REG_DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < REG_DEPTH; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_val[r];
                end
                if (res_set[r]) begin
                    busy[r] <= 1'b1;
                end else if (wr_hit[r]) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    // Independent lookup per read port; unmatched (out-of-range) addresses read 0, not busy.
    always_comb begin : rd_lookup
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            for (int unsigned r = 0; r < REG_DEPTH; r++) begin
                if (bus.i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) begin
                    rd_data_c[k*DATA_WIDTH +: DATA_WIDTH] = regs[r];
                    rd_busy_c[k]                          = busy[r];
`ifdef REGFILE_BYPASS_EN
                    if (wr_hit[r]) begin
                        rd_data_c[k*DATA_WIDTH +: DATA_WIDTH] = wr_val[r];
                        rd_busy_c[k]                          = 1'b0;
                    end
`endif
                end
            end
        end
    end

    assign bus.o_rd_data   = rd_data_c;
    assign bus.o_rd_busy   = rd_busy_c;
    assign bus.o_res_ready = res_ready_c;
    assign bus.o_busy_vec  = busy;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed + random bench for register_file_mp against an array/scoreboard reference model.
module tb_register_file_mp;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 5;
    localparam int unsigned RD = 32;
    localparam int unsigned NR = 2;
    localparam int unsigned NW = 2;

    logic i_clk = 1'b0;
    logic i_arst;
    always #5 i_clk = ~i_clk;

    register_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_DEPTH(RD),
                          .NUM_RD(NR), .NUM_WR(NW)) rf_bus ();

    register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_DEPTH(RD),
                       .NUM_RD(NR), .NUM_WR(NW)) dut (
        .i_clk (i_clk),
        .i_arst(i_arst),
        .bus   (rf_bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] m_regs [RD];
    logic          m_busy [RD];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int r = 0; r < int'(RD); r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic drive(input logic [1:0] we, input int a0, input logic [63:0] d0,
                         input int a1, input logic [63:0] d1,
                         input logic re, input int ra, input int r0, input int r1);
        rf_bus.i_wr_en    = we;
        rf_bus.i_wr_addr  = {AW'(a1), AW'(a0)};
        rf_bus.i_wr_data  = {d1, d0};
        rf_bus.i_res_en   = re;
        rf_bus.i_res_addr = AW'(ra);
        rf_bus.i_rd_addr  = {AW'(r1), AW'(r0)};
    endtask

    function automatic int wr_addr_of(input int j);
        return int'(rf_bus.i_wr_addr[j*AW +: AW]);
    endfunction

    function automatic logic model_ready();
        int ra;
        ra = int'(rf_bus.i_res_addr);
        if (ra == 0 || ra >= int'(RD)) return 1'b1;
        if (!m_busy[ra]) return 1'b1;
        for (int j = 0; j < int'(NW); j++) begin
            if (rf_bus.i_wr_en[j] && wr_addr_of(j) == ra) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Compare every output against the model for the inputs currently applied.
    task automatic check_all();
        int            a;
        logic [DW-1:0] exp_d;
        logic          exp_b;
        logic [RD-1:0] bv;
        for (int k = 0; k < int'(NR); k++) begin
            a     = int'(rf_bus.i_rd_addr[k*AW +: AW]);
            exp_d = '0;
            exp_b = 1'b0;
            if (a != 0 && a < int'(RD)) begin
                exp_d = m_regs[a];
                exp_b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < int'(NW); j++) begin
                    if (rf_bus.i_wr_en[j] && wr_addr_of(j) == a) begin
                        exp_d = rf_bus.i_wr_data[j*DW +: DW];
                        exp_b = 1'b0;
                    end
                end
`endif
            end
            check($sformatf("rd_data%0d@x%0d", k, a), rf_bus.o_rd_data[k*DW +: DW], exp_d);
            check($sformatf("rd_busy%0d@x%0d", k, a), 64'(rf_bus.o_rd_busy[k]), 64'(exp_b));
        end
        check("res_ready", 64'(rf_bus.o_res_ready), 64'(model_ready()));
        for (int r = 0; r < int'(RD); r++) bv[r] = m_busy[r];
        check("busy_vec", 64'(rf_bus.o_busy_vec), 64'(bv));
    endtask

    task automatic sample();
        @(negedge i_clk);
        check_all();
    endtask

    // Apply the rising edge to the model: writes (highest port last), then reservation.
    task automatic advance();
        logic [DW-1:0] n_regs [RD];
        logic          n_busy [RD];
        logic          rdy;
        int            wa;
        int            ra;
        n_regs = m_regs;
        n_busy = m_busy;
        rdy    = model_ready();
        for (int j = 0; j < int'(NW); j++) begin
            wa = wr_addr_of(j);
            if (rf_bus.i_wr_en[j] && wa != 0 && wa < int'(RD)) begin
                n_regs[wa] = rf_bus.i_wr_data[j*DW +: DW];
                n_busy[wa] = 1'b0;
            end
        end
        ra = int'(rf_bus.i_res_addr);
        if (rf_bus.i_res_en && rdy && ra != 0 && ra < int'(RD)) n_busy[ra] = 1'b1;
        @(posedge i_clk);
        #1;
        m_regs = n_regs;
        m_busy = n_busy;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        int wa0, wa1, r0, r1;
        i_arst = 1'b1;
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
        reset_model();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_arst = 1'b0;
        #1;

        // Post-reset sweep of all addresses on both ports
        for (int a = 0; a < int'(RD); a++) begin
            drive(2'b00, 0, 0, 0, 0, 1'b0, a, a, int'(RD) - 1 - a);
            sample();
            check("reset_res_ready", 64'(rf_bus.o_res_ready), 64'd1);
            advance();
        end

        // Same-address write: port 1 wins
        drive(2'b11, 3, 64'h1111, 3, 64'h2222, 1'b0, 0, 3, 3);
        step();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 3, 3);
        sample();
        check("x3_port_priority", rf_bus.o_rd_data[DW-1:0], 64'h2222);
        advance();

        // Writes to x0 are ignored
        drive(2'b01, 0, 64'hFFFF, 0, 0, 1'b0, 0, 0, 0);
        step();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
        sample();
        check("x0_reads_zero", rf_bus.o_rd_data[DW-1:0], 64'h0);
        advance();

        // Reserve x7, re-request stalls, writeback clears
        drive(2'b00, 0, 0, 0, 0, 1'b1, 7, 7, 7);
        sample();
        check("x7_first_ready", 64'(rf_bus.o_res_ready), 64'd1);
        advance();
        sample();
        check("x7_again_ready", 64'(rf_bus.o_res_ready), 64'd0);
        advance();
        drive(2'b10, 0, 0, 7, 64'h55, 1'b0, 0, 7, 7);
        sample();
        check("x7_still_busy", 64'(rf_bus.o_busy_vec[7]), 64'd1);
        advance();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 7, 7);
        sample();
        check("x7_cleared", 64'(rf_bus.o_busy_vec[7]), 64'd0);
        check("x7_data", rf_bus.o_rd_data[DW-1:0], 64'h55);
        advance();

        // Same-cycle reserve and writeback on busy x9: set wins
        drive(2'b00, 0, 0, 0, 0, 1'b1, 9, 9, 9);
        step();
        drive(2'b01, 9, 64'h99, 0, 0, 1'b1, 9, 9, 9);
        sample();
        check("x9_ready_on_wb", 64'(rf_bus.o_res_ready), 64'd1);
        advance();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 9, 9);
        sample();
        check("x9_data", rf_bus.o_rd_data[DW-1:0], 64'h99);
        check("x9_still_busy", 64'(rf_bus.o_busy_vec[9]), 64'd1);
        advance();

        // Read of busy x4 in the cycle it is written back
        drive(2'b01, 4, 64'h4444, 0, 0, 1'b0, 0, 4, 4);
        step();
        drive(2'b00, 0, 0, 0, 0, 1'b1, 4, 4, 4);
        step();
        drive(2'b01, 4, 64'hBEEF, 0, 0, 1'b0, 0, 4, 4);
        sample();
`ifdef REGFILE_BYPASS_EN
        check("x4_bypass_data", rf_bus.o_rd_data[DW-1:0], 64'hBEEF);
        check("x4_bypass_busy", 64'(rf_bus.o_rd_busy[0]), 64'd0);
`else
        check("x4_old_data", rf_bus.o_rd_data[DW-1:0], 64'h4444);
        check("x4_old_busy", 64'(rf_bus.o_rd_busy[0]), 64'd1);
`endif
        advance();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 4, 4);
        sample();
        check("x4_next_data", rf_bus.o_rd_data[DW-1:0], 64'hBEEF);
        check("x4_next_busy", 64'(rf_bus.o_rd_busy[0]), 64'd0);
        advance();

        // Asynchronous reset with x5 = 0xAA pending
        drive(2'b01, 5, 64'hAA, 0, 0, 1'b1, 5, 5, 5);
        step();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5, 5);
        sample();
        check("x5_before_rst", rf_bus.o_rd_data[DW-1:0], 64'hAA);
        #1 i_arst = 1'b1;
        #1;
        check("x5_async_rst_data", rf_bus.o_rd_data[DW-1:0], 64'h0);
        check("x5_async_rst_busyvec", 64'(rf_bus.o_busy_vec), 64'h0);
        check("x5_async_rst_rdbusy", 64'(rf_bus.o_rd_busy), 64'h0);
        reset_model();
        @(posedge i_clk);
        #1 i_arst = 1'b0;

        // Randomized traffic with frequent address collisions
        for (int n = 0; n < 600; n++) begin
            wa0 = int'($urandom_range(0, RD - 1));
            wa1 = ($urandom_range(0, 3) == 0) ? wa0 : int'($urandom_range(0, RD - 1));
            r0  = ($urandom_range(0, 1) == 0) ? wa0 : int'($urandom_range(0, RD - 1));
            r1  = ($urandom_range(0, 1) == 0) ? wa1 : int'($urandom_range(0, RD - 1));
            drive(2'($urandom_range(0, 3)), wa0, {$urandom(), $urandom()},
                  wa1, {$urandom(), $urandom()},
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), r0, r1);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
